// File: rtl/add_sub_arb_32.sv
// Two-requester add/subtract unit: round-robin arbiter feeding a single
// registered ripple-carry adder/subtractor, one operation per two cycles.
module add_sub_arb_32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [DATA_WIDTH-1:0] A0,
    input  logic [DATA_WIDTH-1:0] B0,
    input  logic                  SnA0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] A1,
    input  logic [DATA_WIDTH-1:0] B1,
    input  logic                  SnA1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  CO,
    output logic                  VALID,
    output logic                  VALID_ID
);

    // state | meaning
    // IDLE  | sampling REQ0/REQ1, operand registers hold
    // EXEC  | captured operation in the adder, result registered this edge
    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_take;
    logic                  w_win;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic                  r_ops;
    logic                  r_sel;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_co;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_win       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_EXEC;
                    // On a tie the requester not served last wins.
                    w_win       = (REQ0 && REQ1) ? ~r_last : REQ1;
                end
            end
            S_EXEC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_ops    <= 1'b0;
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            Y        <= '0;
            CO       <= 1'b0;
            VALID    <= 1'b0;
            VALID_ID <= 1'b0;
        end else begin
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            VALID <= 1'b0;
            if (w_take) begin
                r_opa <= w_win ? A1   : A0;
                r_opb <= w_win ? B1   : B0;
                r_ops <= w_win ? SnA1 : SnA0;
                r_sel <= w_win;
                GNT0  <= ~w_win;
                GNT1  <= w_win;
            end
            if (r_state == S_EXEC) begin
                Y        <= w_sum;
                CO       <= w_co;
                VALID_ID <= r_sel;
                VALID    <= 1'b1;
                r_last   <= r_sel;
            end
        end
    end

    RC_ADD_SUB_32 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rc_add_sub (
        .i_a  (r_opa),
        .i_b  (r_opb),
        .i_sna(r_ops),
        .o_y  (w_sum),
        .o_co (w_co)
    );

endmodule

// Ripple-carry adder/subtractor: subtract as A + ~B + 1.
module RC_ADD_SUB_32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_sna,
    output logic [DATA_WIDTH-1:0] o_y,
    output logic                  o_co
);

    logic [DATA_WIDTH-1:0] w_bx;
    logic                  w_carry;

    always_comb begin
        w_bx    = i_sna ? ~i_b : i_b;
        w_carry = i_sna;
        o_y     = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            o_y[i]  = i_a[i] ^ w_bx[i] ^ w_carry;
            w_carry = (i_a[i] & w_bx[i]) | (w_carry & (i_a[i] ^ w_bx[i]));
        end
        o_co = w_carry;
    end

endmodule

// File: tb/tb_add_sub_arb_32.sv
// Scoreboard bench for add_sub_arb_32: expected results queued at stimulus
// time, popped and compared whenever VALID pulses.
module tb_add_sub_arb_32;

    typedef struct packed {
        logic [31:0] y;
        logic        co;
        logic        id;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ0 = 1'b0;
    logic [31:0] A0 = '0;
    logic [31:0] B0 = '0;
    logic        SnA0 = 1'b0;
    logic        REQ1 = 1'b0;
    logic [31:0] A1 = '0;
    logic [31:0] B1 = '0;
    logic        SnA1 = 1'b0;
    logic        GNT0;
    logic        GNT1;
    logic [31:0] Y;
    logic        CO;
    logic        VALID;
    logic        VALID_ID;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_last_y = '0;

    add_sub_arb_32 #(.DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .A0(A0), .B0(B0), .SnA0(SnA0),
        .REQ1(REQ1), .A1(A1), .B1(B1), .SnA1(SnA1),
        .GNT0(GNT0), .GNT1(GNT1),
        .Y(Y), .CO(CO), .VALID(VALID), .VALID_ID(VALID_ID)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic id);
        logic [32:0] r;
        exp_t        e;
        r    = {1'b0, a} + {1'b0, (s ? ~b : b)} + {32'd0, s};
        e.y  = r[31:0];
        e.co = r[32];
        e.id = id;
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        sb.push_back(e);
        m_last_y = e.y;
    endtask

    // Scoreboard and protocol monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (RST) begin
            n_chk++;
            if ((GNT0 && GNT1) || (VALID && (GNT0 || GNT1))) begin
                n_err++;
                $display("FAIL excl_gnt_valid: GNT0=%b GNT1=%b VALID=%b, required at most one high", GNT0, GNT1, VALID);
            end
            if (VALID) begin
                exp_t e;
                n_chk++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: VALID=1 Y=%h ID=%b, required no result pending", Y, VALID_ID);
                end else begin
                    e = sb.pop_front();
                    if ({Y, CO, VALID_ID} !== {e.y, e.co, e.id}) begin
                        n_err++;
                        $display("FAIL result: Y=%h CO=%b ID=%b, required Y=%h CO=%b ID=%b",
                                 Y, CO, VALID_ID, e.y, e.co, e.id);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        tick();
        RST = 1'b0;
        #1;
        n_chk++;
        if ({Y, CO, VALID, VALID_ID, GNT0, GNT1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: Y=%h CO=%b VALID=%b ID=%b GNT=%b%b, required all 0",
                     Y, CO, VALID, VALID_ID, GNT0, GNT1);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_at_reset: %0d results outstanding, required 0", sb.size());
        end
        sb.delete();
        tick();
        RST = 1'b1;
    endtask

    task automatic test_single_add;
        REQ0 = 1'b1; A0 = 32'd10; B0 = 32'd20; SnA0 = 1'b0;
        push_exp(model(A0, B0, SnA0, 1'b0));
        tick();
        n_chk++;
        if ({GNT0, GNT1} !== 2'b10) begin
            n_err++;
            $display("FAIL single_gnt: GNT0GNT1=%b%b, required 10", GNT0, GNT1);
        end
        REQ0 = 1'b0;
        tick();
        n_chk++;
        if (VALID !== 1'b1 || Y !== 32'h0000001E || CO !== 1'b0 || VALID_ID !== 1'b0) begin
            n_err++;
            $display("FAIL single_valid: VALID=%b Y=%h CO=%b ID=%b, required 1 0000001e 0 0", VALID, Y, CO, VALID_ID);
        end
        tick();
        n_chk++;
        if (VALID !== 1'b0 || Y !== 32'h0000001E) begin
            n_err++;
            $display("FAIL single_hold: VALID=%b Y=%h, required 0 0000001e", VALID, Y);
        end
    endtask

    task automatic test_operand_change;
        REQ0 = 1'b1; A0 = 32'd10; B0 = 32'd20; SnA0 = 1'b0;
        push_exp(model(32'd10, 32'd20, 1'b0, 1'b0));
        tick();
        REQ0 = 1'b0; A0 = 32'd99; B0 = 32'd7; SnA0 = 1'b1;
        tick();
        n_chk++;
        if (VALID !== 1'b1 || Y !== 32'h0000001E) begin
            n_err++;
            $display("FAIL operand_change: VALID=%b Y=%h, required 1 0000001e", VALID, Y);
        end
        tick();
    endtask

    task automatic test_sub_carry;
        REQ1 = 1'b1; A1 = 32'h80001234; B1 = 32'h80004321; SnA1 = 1'b0;
        push_exp(model(A1, B1, SnA1, 1'b1));
        tick();
        n_chk++;
        if ({GNT0, GNT1} !== 2'b01) begin
            n_err++;
            $display("FAIL carry_gnt: GNT0GNT1=%b%b, required 01", GNT0, GNT1);
        end
        REQ1 = 1'b0;
        tick();
        n_chk++;
        if (VALID !== 1'b1 || Y !== 32'h00005555 || CO !== 1'b1 || VALID_ID !== 1'b1) begin
            n_err++;
            $display("FAIL carry_valid: VALID=%b Y=%h CO=%b ID=%b, required 1 00005555 1 1", VALID, Y, CO, VALID_ID);
        end
        tick();
    endtask

    task automatic test_reset_mid_exec;
        REQ0 = 1'b1; A0 = 32'd0; B0 = 32'd4; SnA0 = 1'b0;
        tick();
        n_chk++;
        if (GNT0 !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_gnt: GNT0=%b, required 1", GNT0);
        end
        REQ0 = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        n_chk++;
        if ({Y, CO, VALID, VALID_ID, GNT0, GNT1} !== '0) begin
            n_err++;
            $display("FAIL midrst_async: Y=%h CO=%b VALID=%b ID=%b GNT=%b%b, required all 0",
                     Y, CO, VALID, VALID_ID, GNT0, GNT1);
        end
        tick();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (VALID !== 1'b0 || Y !== 32'd0) begin
                n_err++;
                $display("FAIL midrst_discard: VALID=%b Y=%h, required 0 00000000", VALID, Y);
            end
        end
        REQ0 = 1'b1;
        push_exp(model(A0, B0, SnA0, 1'b0));
        tick();
        REQ0 = 1'b0;
        tick();
        n_chk++;
        if (VALID !== 1'b1 || Y !== 32'h00000004) begin
            n_err++;
            $display("FAIL midrst_retry: VALID=%b Y=%h, required 1 00000004", VALID, Y);
        end
        tick();
    endtask

    task automatic test_both_same_edge;
        test_reset();
        REQ0 = 1'b1; A0 = 32'd10; B0 = 32'd20; SnA0 = 1'b1;
        REQ1 = 1'b1; A1 = 32'd15; B1 = 32'd12; SnA1 = 1'b1;
        push_exp('{y: 32'hFFFFFFF6, co: 1'b0, id: 1'b0});
        push_exp('{y: 32'h00000003, co: 1'b1, id: 1'b1});
        tick();
        n_chk++;
        if ({GNT0, GNT1} !== 2'b10) begin
            n_err++;
            $display("FAIL tie_first_gnt: GNT0GNT1=%b%b, required 10", GNT0, GNT1);
        end
        REQ0 = 1'b0;
        tick();
        tick();
        n_chk++;
        if ({GNT0, GNT1} !== 2'b01) begin
            n_err++;
            $display("FAIL tie_second_gnt: GNT0GNT1=%b%b, required 01", GNT0, GNT1);
        end
        REQ1 = 1'b0;
        tick();
        n_chk++;
        if (VALID !== 1'b1 || VALID_ID !== 1'b1 || Y !== 32'h00000003) begin
            n_err++;
            $display("FAIL tie_second_valid: VALID=%b ID=%b Y=%h, required 1 1 00000003", VALID, VALID_ID, Y);
        end
        tick();
    endtask

    task automatic test_round_robin;
        logic w;
        REQ0 = 1'b1; A0 = $urandom; B0 = $urandom; SnA0 = 1'($urandom_range(0, 1));
        REQ1 = 1'b1; A1 = $urandom; B1 = $urandom; SnA1 = 1'($urandom_range(0, 1));
        for (int i = 0; i < 6; i++) begin
            w = 1'(i % 2);
            if (w) push_exp(model(A1, B1, SnA1, 1'b1));
            else   push_exp(model(A0, B0, SnA0, 1'b0));
            tick();
            n_chk++;
            if ({GNT0, GNT1} !== {~w, w}) begin
                n_err++;
                $display("FAIL rr_gnt[%0d]: GNT0GNT1=%b%b, required %b%b", i, GNT0, GNT1, ~w, w);
            end
            if (w) begin A1 = $urandom; B1 = $urandom; SnA1 = 1'($urandom_range(0, 1)); end
            else   begin A0 = $urandom; B0 = $urandom; SnA0 = 1'($urandom_range(0, 1)); end
            if (i == 5) begin REQ0 = 1'b0; REQ1 = 1'b0; end
            tick();
            n_chk++;
            if (VALID !== 1'b1 || VALID_ID !== w) begin
                n_err++;
                $display("FAIL rr_valid[%0d]: VALID=%b ID=%b, required 1 %b", i, VALID, VALID_ID, w);
            end
        end
    endtask

    task automatic test_idle_hold;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (VALID !== 1'b0 || GNT0 !== 1'b0 || GNT1 !== 1'b0 || Y !== m_last_y) begin
                n_err++;
                $display("FAIL idle_hold: VALID=%b GNT=%b%b Y=%h, required 0 00 %h", VALID, GNT0, GNT1, Y, m_last_y);
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_results: %0d results never produced, required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_add();
        test_operand_change();
        test_sub_carry();
        test_reset_mid_exec();
        test_both_same_edge();
        test_round_robin();
        test_idle_hold();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
